// File: rtl/gbuf_tile_reader_pkg.sv
// Shared definitions for the global-buffer tile reader: default buffer widths and
// the reader FSM state encoding.
package gbuf_tile_reader_pkg;

    localparam int GB_DATA_WIDTH = 32;
    localparam int GB_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ISSUE = 2'd1,
        TR_DRAIN = 2'd2,
        TR_DONE  = 2'd3
    } tr_state_t;

endpackage

// File: rtl/gbuf_tile_reader_fifo.sv
// Small synchronous FIFO with occupancy count; the reader stores {last, data} words in it.
module npu_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q;

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/gbuf_tile_reader.sv
// Walks a row-strided tile out of the global buffer and streams it on valid/ready,
// issuing reads only when the skid FIFO is guaranteed room for the returning word.
module gbuf_tile_reader
    import gbuf_tile_reader_pkg::*;
#(
    parameter int DATA_WIDTH = GB_DATA_WIDTH,
    parameter int ADDR_WIDTH = GB_ADDR_WIDTH,
    parameter int DIM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  gb_ce,
    output logic                  gb_we,
    output logic [ADDR_WIDTH-1:0] gb_addr,
    input  logic [DATA_WIDTH-1:0] gb_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output tr_state_t             dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]          DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DIM_WIDTH-1:0] DIM_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    tr_state_t             state_q, state_d;
    logic [DIM_WIDTH-1:0]  rows_q, cols_q, r_cnt, c_cnt;
    logic [ADDR_WIDTH-1:0] stride_q, row_ptr, addr_q;
    logic                  inflight, inflight_last;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic [DATA_WIDTH:0]   head;
    logic                  fifo_empty;
    logic                  issue, issue_last, col_end, row_end, pop;

    // A word is transferred on every cycle where m_valid and m_ready are both high;
    // m_valid never drops and m_data never changes while a word waits for m_ready.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue      = (state_q == TR_ISSUE) && (occupancy < DEPTH_LIM);
    assign col_end    = (c_cnt == cols_q - DIM_ONE);
    assign row_end    = (r_cnt == rows_q - DIM_ONE);
    assign issue_last = issue && col_end && row_end;
    assign pop        = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TR_IDLE: begin
                if (start) begin
                    state_d = (rows != '0 && cols != '0) ? TR_ISSUE : TR_DONE;
                end
            end
            TR_ISSUE: if (issue_last) state_d = TR_DRAIN;
            TR_DRAIN: if (pop && head[DATA_WIDTH]) state_d = TR_DONE;
            TR_DONE:  state_d = TR_IDLE;
            default:  state_d = TR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= TR_IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            r_cnt         <= '0;
            c_cnt         <= '0;
            stride_q      <= '0;
            row_ptr       <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (state_q == TR_IDLE && start) begin
                rows_q   <= rows;
                cols_q   <= cols;
                stride_q <= row_stride;
                row_ptr  <= base_addr;
                addr_q   <= base_addr;
                r_cnt    <= '0;
                c_cnt    <= '0;
            end else if (issue) begin
                if (col_end) begin
                    c_cnt   <= '0;
                    r_cnt   <= r_cnt + DIM_ONE;
                    row_ptr <= row_ptr + stride_q;
                    addr_q  <= row_ptr + stride_q;
                end else begin
                    c_cnt  <= c_cnt + DIM_ONE;
                    addr_q <= addr_q + ADDR_ONE;
                end
            end
        end
    end

    npu_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, gb_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign gb_ce     = issue;
    assign gb_we     = 1'b0;
    assign gb_addr   = addr_q;
    assign m_valid   = !fifo_empty;
    assign m_data    = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last    = m_valid && head[DATA_WIDTH];
    assign busy      = (state_q == TR_ISSUE) || (state_q == TR_DRAIN);
    assign done      = (state_q == TR_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gbuf_tile_reader.sv
// Bench for gbuf_tile_reader: behavioural SRAM, expected-word and expected-address queues.
module tb_gbuf_tile_reader;
    import gbuf_tile_reader_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DIMW  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [DIMW-1:0] rows = '0;
    logic [DIMW-1:0] cols = '0;
    logic [AW-1:0]   row_stride = '0;
    logic            busy, done, gb_ce, gb_we, m_valid, m_last;
    logic [AW-1:0]   gb_addr;
    logic [DW-1:0]   gb_rdata = '0;
    logic            m_ready = 1'b1;
    logic [DW-1:0]   m_data;
    tr_state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_exp_q[$];

    int issued = 0, popped = 0, max_out = 0, last_hs_cyc = -1, valid_cycles = 0;
    int rdy_mode = 0, rdy_lo_from = 0, rdy_lo_to = 0;

    gbuf_tile_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .rows       (rows),
        .cols       (cols),
        .row_stride (row_stride),
        .busy       (busy),
        .done       (done),
        .gb_ce      (gb_ce),
        .gb_we      (gb_we),
        .gb_addr    (gb_addr),
        .gb_rdata   (gb_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    // Global buffer model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (gb_ce) gb_rdata <= word_of(gb_addr);
    end

    // Consumer ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = !(cyc >= rdy_lo_from && cyc <= rdy_lo_to);
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) valid_cycles++;
            if (gb_ce) begin
                check_eq("ce_credit", 64'(issued - popped < DEPTH), 64'd1);
                check_eq("gb_we", 64'(gb_we), 64'd0);
                if (addr_exp_q.size() == 0) check_eq("extra_ce", 64'd1, 64'd0);
                else check_eq("gb_addr", 64'(gb_addr), 64'(addr_exp_q.pop_front()));
                issued++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check_eq("extra_beat", 64'd1, 64'd0);
                else check_eq("beat", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
                popped++;
                if (m_last) last_hs_cyc = cyc;
            end
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    task automatic push_expected(input logic [AW-1:0] b, input int nr, input int nc,
                                 input logic [AW-1:0] s);
        logic [AW-1:0] a;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                a = b + AW'(r) * s + AW'(c);
                addr_exp_q.push_back(a);
                exp_q.push_back({(r == nr - 1 && c == nc - 1), word_of(a)});
            end
        end
    endtask

    // Drives one tile; optionally re-pulses start mid-tile with other parameters.
    task automatic run_tile(input string name, input logic [AW-1:0] b, input int nr,
                            input int nc, input logic [AW-1:0] s, input bit restart);
        int start_cyc, done_cyc, n, ce0, pop0, val0;
        bit got_done, busy_run, busy_at_done;
        push_expected(b, nr, nc, s);
        ce0 = issued; pop0 = popped; val0 = valid_cycles; max_out = 0;
        got_done = 0; busy_run = 0; busy_at_done = 1; done_cyc = 0; n = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; rows = DIMW'(nr); cols = DIMW'(nc); row_stride = s;
        start_cyc = cyc;
        while (!got_done && n < 300) begin
            @(negedge clk);
            if (cyc == start_cyc + 1) busy_run = busy;
            if (done) begin
                got_done = 1; done_cyc = cyc; busy_at_done = busy;
            end
            @(posedge clk); #1;
            n++;
            start = restart && (n == 3);
            if (start) begin
                base_addr = 16'h0100; rows = 8'd1; cols = 8'd1; row_stride = 16'h0;
            end
        end
        start = 1'b0;
        check_eq({name, "_done_seen"}, 64'(got_done), 64'd1);
        if (nr * nc == 0) check_eq({name, "_done_lat0"}, 64'(done_cyc - start_cyc), 64'd1);
        else check_eq({name, "_done_lat"}, 64'(done_cyc - last_hs_cyc), 64'd1);
        check_eq({name, "_busy_run"}, 64'(busy_run), 64'(nr * nc != 0));
        check_eq({name, "_busy_done"}, 64'(busy_at_done), 64'd0);
        check_eq({name, "_ce_cnt"}, 64'(issued - ce0), 64'(nr * nc));
        check_eq({name, "_beats"}, 64'(popped - pop0), 64'(nr * nc));
        if (nr * nc == 0) check_eq({name, "_no_valid"}, 64'(valid_cycles - val0), 64'd0);
        check_eq({name, "_exp_left"}, 64'(exp_q.size() + addr_exp_q.size()), 64'd0);
        @(negedge clk);
        check_eq({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_ce"}, 64'(gb_ce), 64'd0);
        check_eq({name, "_we"}, 64'(gb_we), 64'd0);
        check_eq({name, "_addr"}, 64'(gb_addr), 64'd0);
        check_eq({name, "_valid"}, 64'(m_valid), 64'd0);
        check_eq({name, "_data"}, 64'(m_data), 64'd0);
        check_eq({name, "_last"}, 64'(m_last), 64'd0);
        check_eq({name, "_busy"}, 64'(busy), 64'd0);
        check_eq({name, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        rdy_mode = 0;
        run_tile("t1", 16'h0010, 2, 3, 16'h0008, 1'b0);

        rdy_mode = 1; rdy_lo_from = cyc + 3; rdy_lo_to = cyc + 10;
        run_tile("t2", 16'h0010, 2, 3, 16'h0008, 1'b0);
        check_eq("t2_peak_outstanding", 64'(max_out), 64'(DEPTH));

        rdy_mode = 0;
        run_tile("t3", 16'hFFFE, 1, 4, 16'h0000, 1'b0);
        run_tile("t4", 16'h0040, 0, 5, 16'h0008, 1'b0);
        run_tile("t4b", 16'h0040, 3, 0, 16'h0008, 1'b0);
        run_tile("t5", 16'h0010, 2, 3, 16'h0008, 1'b1);

        // Reset while issuing with the FIFO three deep and a read in flight.
        rdy_mode = 3;
        push_expected(16'h0200, 2, 3, 16'h0010);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0200; rows = 8'd2; cols = 8'd3; row_stride = 16'h0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete(); addr_exp_q.delete(); issued = 0; popped = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        @(negedge clk);
        check_eq("t6_inflight_dropped", 64'(m_valid), 64'd0);
        rdy_mode = 0;
        run_tile("t6_after", 16'h0200, 2, 3, 16'h0010, 1'b0);

        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            run_tile("rnd", AW'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 4),
                     $urandom_range(1, 5), AW'($urandom_range(0, 64)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
